icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache; the responder on the datapath's instruction side of datapath_cache_if. It serves imemREN/imemaddr with ihit/imemload.
- On a miss it becomes the initiator toward the memory controller, using iREN/iaddr and waiting on iwait/iload.
- Sits between the pipelined datapath's fetch stage and the arbitrated memory controller.
- One-word blocks, no writes, no coherence.

---
 rtl/icache_direct_pkg.sv | 28 ++
 rtl/icache_frame_array.sv | 61 ++++++
 rtl/icache_direct.sv | 107 ++++++++++
 tb/tb_icache_direct.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache: word/frame layout,
// controller states and the tag-extraction helper.
package icache_direct_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned ICACHE_NSETS = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [WORD_W-3:0] waddr_t;

  // Tag is kept zero-extended to a full word address so the frame layout
  // does not change with NSETS.
  typedef struct packed {
    logic   valid;
    waddr_t tag;
    word_t  data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  function automatic waddr_t tag_of(input waddr_t word_addr, input int unsigned idxw);
    return word_addr >> idxw;
  endfunction

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage for the instruction cache: one synchronous write port, one
// combinational read port, bulk valid clear. Only valid bits are reset.
module icache_frame_array
  import icache_direct_pkg::*;
#(
  parameter  int unsigned NSETS = ICACHE_NSETS,
  localparam int unsigned IDXW  = $clog2(NSETS)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                clear,
  input  logic                we,
  input  logic [IDXW-1:0]     widx,
  input  icache_frame_t       wdata,
  input  logic [IDXW-1:0]     ridx,
  output icache_frame_t       rdata
);

  logic [NSETS-1:0] valid_d, valid_q;
  waddr_t           tag_d  [NSETS];
  waddr_t           tag_q  [NSETS];
  word_t            data_d [NSETS];
  word_t            data_q [NSETS];

  // Next-state for every frame: clear first, then the fill may re-mark its frame.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = {NSETS{1'b0}};
    end else begin
      valid_d = valid_q;
    end
    if (we) begin
      valid_d[widx] = wdata.valid;
      tag_d[widx]   = wdata.tag;
      data_d[widx]  = wdata.data;
    end else begin
      valid_d = valid_d;
    end
  end

  // Valid bits with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      valid_q <= {NSETS{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/data payload, never reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rdata = {valid_q[ridx], tag_q[ridx], data_q[ridx]};

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: combinational hit path, and an
// IDLE/FETCH controller that fills one word from memory on a miss.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter  int unsigned NSETS = ICACHE_NSETS,
  localparam int unsigned IDXW  = $clog2(NSETS)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  input  logic              flush
);

  icache_state_t state_d, state_q;
  waddr_t        miss_word_d, miss_word_q;
  logic          flush_seen_d, flush_seen_q;

  icache_frame_t rd_frame_s;
  icache_frame_t wr_frame_s;
  logic          fill_we_s;
  logic          hit_s;
  logic          unused_byte_off;

  assign unused_byte_off = ^imemaddr[1:0];

  icache_frame_array #(.NSETS(NSETS)) u_frames (
    .clk   (CLK),
    .nrst  (nRST),
    .clear (flush),
    .we    (fill_we_s),
    .widx  (miss_word_q[IDXW-1:0]),
    .wdata (wr_frame_s),
    .ridx  (imemaddr[IDXW+1:2]),
    .rdata (rd_frame_s)
  );

  assign hit_s = (state_q == IDLE) && imemREN && !flush && rd_frame_s.valid &&
                 (rd_frame_s.tag == tag_of(imemaddr[WORD_W-1:2], IDXW));

  // A flush seen at any point during FETCH poisons the fill in flight.
  assign wr_frame_s = {!(flush || flush_seen_q), tag_of(miss_word_q, IDXW), iload};
  assign iaddr      = {miss_word_q, 2'b00};

  // Controller next-state and datapath-facing outputs.
  always_comb begin
    state_d      = state_q;
    miss_word_d  = miss_word_q;
    flush_seen_d = flush_seen_q;
    ihit         = 1'b0;
    imemload     = {WORD_W{1'b0}};
    iREN         = 1'b0;
    fill_we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        ihit = hit_s;
        if (hit_s) begin
          imemload = rd_frame_s.data;
        end else begin
          imemload = {WORD_W{1'b0}};
        end
        if (imemREN && !hit_s && !flush) begin
          miss_word_d = imemaddr[WORD_W-1:2];
          state_d     = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        iREN = 1'b1;
        if (!iwait) begin
          fill_we_s    = 1'b1;
          flush_seen_d = 1'b0;
          state_d      = IDLE;
        end else if (flush) begin
          flush_seen_d = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      miss_word_q  <= {(WORD_W-2){1'b0}};
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_word_q  <= miss_word_d;
      flush_seen_q <= flush_seen_d;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed cycle table for the corner sequences,
// then randomized traffic against a line-level reference model.
module tb_icache_direct;
  import icache_direct_pkg::*;

  localparam int unsigned NS = ICACHE_NSETS;

  logic        CLK = 1'b0;
  logic        nRST, imemREN, ihit, iREN, iwait, flush;
  logic [31:0] imemaddr, imemload, iaddr, iload;

  icache_direct dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .flush(flush)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst_n, ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] ld;
    logic        fl;
    bit          chk;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_addr;
    bit          chk_addr;
  } row_t;

  row_t rows[$];

  // Reference model: cache lines by index, plus one outstanding request.
  bit          m_valid [NS];
  logic [29:0] m_line  [NS];
  logic [31:0] m_data  [NS];
  bit          m_pend, m_poison;
  logic [29:0] m_paddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic t(input logic rs, input logic rn, input logic [31:0] a, input logic w,
                   input logic [31:0] l, input logic f, input bit c, input logic eh,
                   input logic [31:0] el, input logic er, input logic [31:0] ea, input bit ca);
    row_t r;
    r.rst_n = rs; r.ren = rn; r.addr = a; r.wt = w; r.ld = l; r.fl = f;
    r.chk = c; r.e_hit = eh; r.e_load = el; r.e_ren = er; r.e_addr = ea; r.chk_addr = ca;
    rows.push_back(r);
  endtask

  function automatic bit model_hit();
    int unsigned idx;
    idx = imemaddr[31:2] % NS;
    return !m_pend && imemREN && !flush && m_valid[idx] && (m_line[idx] == imemaddr[31:2]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_update();
    int unsigned pidx;
    if (!nRST) begin
      model_clear();
      m_pend = 1'b0; m_poison = 1'b0; m_paddr = 30'd0;
    end else if (m_pend) begin
      if (flush) model_clear();
      if (!iwait) begin
        pidx = m_paddr % NS;
        m_valid[pidx] = !(flush || m_poison);
        m_line[pidx]  = m_paddr;
        m_data[pidx]  = iload;
        m_pend = 1'b0; m_poison = 1'b0;
      end else if (flush) begin
        m_poison = 1'b1;
      end
    end else if (flush) begin
      model_clear();
    end else if (imemREN && !model_hit()) begin
      m_pend  = 1'b1;
      m_paddr = imemaddr[31:2];
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_1234;
  endfunction

  initial begin
    logic        e_hit;
    logic [31:0] e_load;
    logic [31:0] a;
    int unsigned idx;

    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'd0; iwait = 1'b1; iload = 32'd0; flush = 1'b0;
    model_clear();
    m_pend = 1'b0; m_poison = 1'b0; m_paddr = 30'd0;

    // rst ren addr wait load flush | chk hit load iREN iaddr chk_iaddr
    t(0,0,32'h0,1,32'h0,0,             0,0,32'h0,0,32'h0,0);
    t(1,0,32'h0,1,32'h0,0,             1,0,32'h0,0,32'h0,1);
    t(1,1,32'h40,1,32'h0,0,            1,0,32'h0,0,32'h0,0);
    for (int i = 0; i < 3; i++) t(1,1,32'h40,1,32'h0,0, 1,0,32'h0,1,32'h40,1);
    t(1,1,32'h40,0,32'h3C010004,0,     1,0,32'h0,1,32'h40,1);
    t(1,1,32'h40,1,32'h0,0,            1,1,32'h3C010004,0,32'h0,0);
    t(1,1,32'h40,1,32'h0,0,            1,1,32'h3C010004,0,32'h0,0);
    t(1,1,32'h80,1,32'h0,0,            1,0,32'h0,0,32'h0,0);
    t(1,1,32'h80,0,32'hDEADBEEF,0,     1,0,32'h0,1,32'h80,1);
    t(1,1,32'h80,1,32'h0,0,            1,1,32'hDEADBEEF,0,32'h0,0);
    t(1,1,32'h40,1,32'h0,0,            1,0,32'h0,0,32'h0,0);
    t(1,1,32'h40,0,32'h3C010004,0,     1,0,32'h0,1,32'h40,1);
    t(1,1,32'h40,1,32'h0,0,            1,1,32'h3C010004,0,32'h0,0);
    t(1,1,32'h10,1,32'h0,0,            1,0,32'h0,0,32'h0,0);
    t(1,1,32'h24,1,32'h0,0,            1,0,32'h0,1,32'h10,1);
    t(1,1,32'h24,0,32'h11111111,0,     1,0,32'h0,1,32'h10,1);
    t(1,1,32'h24,1,32'h0,0,            1,0,32'h0,0,32'h0,0);
    t(1,1,32'h24,0,32'h22222222,0,     1,0,32'h0,1,32'h24,1);
    t(1,1,32'h24,1,32'h0,0,            1,1,32'h22222222,0,32'h0,0);
    t(1,1,32'h10,1,32'h0,0,            1,1,32'h11111111,0,32'h0,0);
    t(1,1,32'h0,1,32'h0,0,             1,0,32'h0,0,32'h0,0);
    t(1,1,32'h0,0,32'hAAAA0000,0,      1,0,32'h0,1,32'h0,1);
    t(1,1,32'h4,1,32'h0,0,             1,0,32'h0,0,32'h0,0);
    t(1,1,32'h4,0,32'hBBBB0004,0,      1,0,32'h0,1,32'h4,1);
    t(1,1,32'h0,1,32'h0,0,             1,1,32'hAAAA0000,0,32'h0,0);
    t(1,1,32'h4,1,32'h0,1,             1,0,32'h0,0,32'h0,0);
    t(1,1,32'h0,1,32'h0,0,             1,0,32'h0,0,32'h0,0);
    t(1,1,32'h0,0,32'hAAAA0000,0,      1,0,32'h0,1,32'h0,1);
    t(1,1,32'h4,1,32'h0,0,             1,0,32'h0,0,32'h0,0);
    t(1,1,32'h4,0,32'hBBBB0004,0,      1,0,32'h0,1,32'h4,1);
    t(1,1,32'h4,1,32'h0,0,             1,1,32'hBBBB0004,0,32'h0,0);
    t(1,1,32'h8,1,32'h0,0,             1,0,32'h0,0,32'h0,0);
    t(1,1,32'h8,1,32'h0,1,             1,0,32'h0,1,32'h8,1);
    t(1,1,32'h8,0,32'hCCCC0008,0,      1,0,32'h0,1,32'h8,1);
    t(1,1,32'h8,1,32'h0,0,             1,0,32'h0,0,32'h0,0);
    t(1,1,32'h8,0,32'hCCCC0008,0,      1,0,32'h0,1,32'h8,1);
    t(1,1,32'h8,1,32'h0,0,             1,1,32'hCCCC0008,0,32'h0,0);
    t(1,1,32'h4,1,32'h0,0,             1,0,32'h0,0,32'h0,0);
    t(1,1,32'h4,0,32'hBBBB0004,0,      1,0,32'h0,1,32'h4,1);
    t(1,1,32'h4,1,32'h0,0,             1,1,32'hBBBB0004,0,32'h0,0);
    t(1,1,32'hC,1,32'h0,0,             1,0,32'h0,0,32'h0,0);
    t(0,1,32'hC,1,32'h0,0,             1,0,32'h0,1,32'hC,1);
    t(1,0,32'hC,1,32'h0,0,             1,0,32'h0,0,32'h0,1);
    t(1,1,32'h8,1,32'h0,0,             1,0,32'h0,0,32'h0,0);
    t(1,1,32'h8,0,32'hCCCC0008,0,      1,0,32'h0,1,32'h8,1);
    t(1,1,32'h100,1,32'h0,0,           1,0,32'h0,0,32'h0,0);
    t(1,1,32'h100,0,32'h12345678,0,    1,0,32'h0,1,32'h100,1);
    t(1,1,32'h103,1,32'h0,0,           1,1,32'h12345678,0,32'h0,0);
    t(1,0,32'h103,1,32'h0,0,           1,0,32'h0,0,32'h0,0);

    foreach (rows[i]) begin
      @(negedge CLK);
      nRST = rows[i].rst_n; imemREN = rows[i].ren; imemaddr = rows[i].addr;
      iwait = rows[i].wt; iload = rows[i].ld; flush = rows[i].fl;
      #1;
      if (rows[i].chk) begin
        check($sformatf("row%0d_ihit", i), 32'(ihit), 32'(rows[i].e_hit));
        check($sformatf("row%0d_imemload", i), imemload, rows[i].e_load);
        check($sformatf("row%0d_iREN", i), 32'(iREN), 32'(rows[i].e_ren));
        if (rows[i].chk_addr) check($sformatf("row%0d_iaddr", i), iaddr, rows[i].e_addr);
      end
      model_update();
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      nRST    = ($urandom_range(0, 249) != 0);
      imemREN = ($urandom_range(0, 4) != 0);
      a = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a[31:28] = 4'($urandom_range(0, 15));
      imemaddr = a;
      flush = ($urandom_range(0, 29) == 0);
      iwait = ($urandom_range(0, 9) < 6);
      iload = iwait ? $urandom : mem_f({m_paddr, 2'b00});
      #1;
      e_hit = model_hit();
      idx = imemaddr[31:2] % NS;
      e_load = e_hit ? m_data[idx] : 32'd0;
      check("rnd_ihit", 32'(ihit), 32'(e_hit));
      check("rnd_imemload", imemload, e_load);
      check("rnd_iREN", 32'(iREN), 32'(m_pend));
      if (m_pend) check("rnd_iaddr", iaddr, {m_paddr, 2'b00});
      check("rnd_iaddr_lsb", 32'(iaddr[1:0]), 32'd0);
      model_update();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
